alu_issue_decoder: RTL and testbench

ALU_ISSUE_DECODER -- requirements
Module: alu_issue_decoder

---
 rtl/alu_issue_decoder.sv | 198 +++++++++++++++++++
 tb/tb_alu_issue_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_decoder.sv
// MIPS ALU-subset decoder feeding a 2-entry issue FIFO toward the ALU stage.
// Decode is combinational on instr_i; decoded fields are buffered at accept.
module alu_issue_decoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  ctrl_o,
  output logic [4:0]  shamt_o,
  output logic [31:0] imm_o,
  output logic        alu_src_o,
  output logic        reg_write_o,
  output logic        branch_o,
  output logic        illegal_o,
  output logic [7:0]  illegal_cnt_o
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  localparam logic [3:0] CTRL_AND     = 4'd0;
  localparam logic [3:0] CTRL_OR      = 4'd1;
  localparam logic [3:0] CTRL_ADDU    = 4'd2;
  localparam logic [3:0] CTRL_SRAV    = 4'd3;
  localparam logic [3:0] CTRL_BEQ     = 4'd4;
  localparam logic [3:0] CTRL_SLTIU   = 4'd5;
  localparam logic [3:0] CTRL_SUBU    = 4'd6;
  localparam logic [3:0] CTRL_SLT     = 4'd7;
  localparam logic [3:0] CTRL_ADDI    = 4'd8;
  localparam logic [3:0] CTRL_ORI     = 4'd9;
  localparam logic [3:0] CTRL_BNE     = 4'd10;
  localparam logic [3:0] CTRL_SRA     = 4'd13;
  localparam logic [3:0] CTRL_LUI     = 4'd14;
  localparam logic [3:0] CTRL_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        alu_src;
    logic        reg_write;
    logic        branch;
    logic        illegal;
  } entry_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [3:0]  r_ctrl;
  logic        r_ok;
  entry_t      dec;

  // Register-specifier fields are consumed downstream, not here.
  logic        unused_fields;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign imm_sext      = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_zext      = {16'h0000, instr_i[15:0]};
  assign unused_fields = ^instr_i[25:16];

  always_comb begin
    r_ok   = 1'b1;
    r_ctrl = CTRL_ILLEGAL;
    case (funct)
      6'h24:   r_ctrl = CTRL_AND;
      6'h25:   r_ctrl = CTRL_OR;
      6'h21:   r_ctrl = CTRL_ADDU;
      6'h07:   r_ctrl = CTRL_SRAV;
      6'h23:   r_ctrl = CTRL_SUBU;
      6'h2A:   r_ctrl = CTRL_SLT;
      6'h03:   r_ctrl = CTRL_SRA;
      default: r_ok   = 1'b0;
    endcase
  end

  // Default is the illegal encoding; each legal opcode overrides it.
  always_comb begin
    dec           = '0;
    dec.shamt     = instr_i[10:6];
    dec.ctrl      = CTRL_ILLEGAL;
    dec.illegal   = 1'b1;
    case (opcode)
      6'h00: begin
        if (r_ok) begin
          dec.ctrl      = r_ctrl;
          dec.reg_write = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      6'h04: begin
        dec.ctrl    = CTRL_BEQ;
        dec.imm     = imm_sext;
        dec.branch  = 1'b1;
        dec.illegal = 1'b0;
      end
      6'h05: begin
        dec.ctrl    = CTRL_BNE;
        dec.imm     = imm_sext;
        dec.branch  = 1'b1;
        dec.illegal = 1'b0;
      end
      6'h08: begin
        dec.ctrl      = CTRL_ADDI;
        dec.imm       = imm_sext;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      6'h0B: begin
        dec.ctrl      = CTRL_SLTIU;
        dec.imm       = imm_sext;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      6'h0D: begin
        dec.ctrl      = CTRL_ORI;
        dec.imm       = imm_zext;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      6'h0F: begin
        dec.ctrl      = CTRL_LUI;
        dec.imm       = imm_zext;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      default: ;
    endcase
  end

  // Handshakes: a beat transfers on a rising edge where valid and ready are
  // both high. Upstream: instr_valid_i/instr_ready_o (ready from registered
  // count only). Downstream: valid_o/ready_i; head outputs hold while stalled.
  entry_t     fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [7:0] illegal_cnt;
  logic       push;
  logic       pop;
  entry_t     head;

  assign instr_ready_o = (count != CNT_FULL);
  assign valid_o       = (count != CNT_EMPTY);
  assign push          = instr_valid_i && instr_ready_o;
  assign pop           = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= dec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= CNT_EMPTY;
      illegal_cnt <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
      if (push && dec.illegal && (illegal_cnt != 8'hFF)) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

  // Empty FIFO presents all-zero fields so reset state is clean without
  // having to clear the storage array.
  assign head          = valid_o ? fifo_mem[rd_ptr] : '0;
  assign ctrl_o        = head.ctrl;
  assign shamt_o       = head.shamt;
  assign imm_o         = head.imm;
  assign alu_src_o     = head.alu_src;
  assign reg_write_o   = head.reg_write;
  assign branch_o      = head.branch;
  assign illegal_o     = head.illegal;
  assign illegal_cnt_o = illegal_cnt;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder: queue-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_alu_issue_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  ctrl_o;
  logic [4:0]  shamt_o;
  logic [31:0] imm_o;
  logic        alu_src_o;
  logic        reg_write_o;
  logic        branch_o;
  logic        illegal_o;
  logic [7:0]  illegal_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [44:0] exp_q[$];
  int          model_cnt = 0;
  bit          fresh = 1'b1;
  bit          chk_en = 1'b0;
  logic [44:0] dut_word;

  assign dut_word = {ctrl_o, shamt_o, imm_o, alu_src_o, reg_write_o, branch_o, illegal_o};

  alu_issue_decoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .ctrl_o        (ctrl_o),
    .shamt_o       (shamt_o),
    .imm_o         (imm_o),
    .alu_src_o     (alu_src_o),
    .reg_write_o   (reg_write_o),
    .branch_o      (branch_o),
    .illegal_o     (illegal_o),
    .illegal_cnt_o (illegal_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction tables.
  function automatic logic [44:0] model_decode(input logic [31:0] w);
    logic [5:0]  op   = w[31:26];
    logic [5:0]  fn   = w[5:0];
    logic [31:0] sext = {{16{w[15]}}, w[15:0]};
    logic [31:0] zext = {16'h0, w[15:0]};
    logic [3:0]  ctrl = 4'd15;
    logic [31:0] imm  = 32'h0;
    bit src = 0, wr = 0, br = 0, ill = 1;
    if (op == 6'h00) begin
      case (fn)
        6'h24: ctrl = 4'd0;
        6'h25: ctrl = 4'd1;
        6'h21: ctrl = 4'd2;
        6'h07: ctrl = 4'd3;
        6'h23: ctrl = 4'd6;
        6'h2A: ctrl = 4'd7;
        6'h03: ctrl = 4'd13;
        default: ctrl = 4'd15;
      endcase
      if (ctrl != 4'd15) begin
        wr = 1; ill = 0;
      end
    end else begin
      case (op)
        6'h04: begin ctrl = 4'd4;  imm = sext; br = 1; ill = 0; end
        6'h05: begin ctrl = 4'd10; imm = sext; br = 1; ill = 0; end
        6'h08: begin ctrl = 4'd8;  imm = sext; src = 1; wr = 1; ill = 0; end
        6'h0B: begin ctrl = 4'd5;  imm = sext; src = 1; wr = 1; ill = 0; end
        6'h0D: begin ctrl = 4'd9;  imm = zext; src = 1; wr = 1; ill = 0; end
        6'h0F: begin ctrl = 4'd14; imm = zext; src = 1; wr = 1; ill = 0; end
        default: ;
      endcase
    end
    return {ctrl, w[10:6], imm, src, wr, br, ill};
  endfunction

  // Model: FIFO contents as a plain queue, updated on each rising edge.
  always @(posedge clk_i) begin
    bit m_push, m_pop;
    logic [44:0] e;
    if (!rst_i) begin
      exp_q.delete();
      model_cnt = 0;
      fresh = 1'b1;
    end else begin
      m_pop  = (exp_q.size() != 0) && ready_i;
      m_push = instr_valid_i && (exp_q.size() < 2);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        e = model_decode(instr_i);
        exp_q.push_back(e);
        if (e[0] && model_cnt < 255) model_cnt++;
        fresh = 1'b0;
      end
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("valid_o", valid_o, exp_q.size() != 0);
      check("instr_ready_o", instr_ready_o, exp_q.size() < 2);
      check("illegal_cnt_o", illegal_cnt_o, model_cnt);
      if (exp_q.size() != 0) check("head", dut_word, exp_q[0]);
      else if (fresh) check("reset_fields", dut_word, 45'h0);
    end
  end

  // driver: hold the word until accepted (ready is registered-only, so it is
  // stable between the negedge and the next posedge)
  task automatic push(input logic [31:0] w);
    int n = 0;
    logic acc;
    instr_i = w;
    instr_valid_i = 1'b1;
    do begin
      acc = instr_ready_o;
      @(negedge clk_i);
      n++;
    end while (!acc && n < 50);
    instr_valid_i = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout: word %08h not accepted after %0d cycles", w, n);
    end
  endtask

  logic [31:0] table_w [12] = '{
    32'h00221824, 32'h00221825, 32'h00221821, 32'h00221807,
    32'h00221823, 32'h0022182A, 32'h0001F0C3, 32'h1022FFFC,
    32'h2C218000, 32'h00221820, 32'h8C220004, 32'h3C01ABCD
  };

  initial begin
    rst_i = 1'b0;
    instr_i = 32'h0;
    instr_valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_en = 1'b1;
    rst_i = 1'b1;

    check("rst_valid", valid_o, 1'b0);
    check("rst_ready", instr_ready_o, 1'b1);
    check("rst_fields", dut_word, 45'h0);
    check("rst_cnt", illegal_cnt_o, 8'd0);

    push(32'h2001FFFF);
    check("addi_valid", valid_o, 1'b1);
    check("addi_ctrl", ctrl_o, 4'd8);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    check("addi_src", alu_src_o, 1'b1);
    check("addi_wr", reg_write_o, 1'b1);

    push(32'h3401FFFF);
    check("ori_ctrl", ctrl_o, 4'd9);
    check("ori_imm", imm_o, 32'h0000FFFF);
    push(32'h3C011234);
    check("lui_ctrl", ctrl_o, 4'd14);
    check("lui_imm", imm_o, 32'h00001234);

    push(32'h00010883);
    check("sra_ctrl", ctrl_o, 4'd13);
    check("sra_shamt", shamt_o, 5'd2);
    check("sra_src", alu_src_o, 1'b0);
    push(32'h1422FFFE);
    check("bne_ctrl", ctrl_o, 4'd10);
    check("bne_branch", branch_o, 1'b1);
    check("bne_wr", reg_write_o, 1'b0);
    check("bne_imm", imm_o, 32'hFFFFFFFE);
    @(negedge clk_i);

    // back-pressure: third word held off until the ALU side drains
    ready_i = 1'b0;
    push(32'h20010001);
    push(32'h20010002);
    check("full_ready", instr_ready_o, 1'b0);
    check("full_head", imm_o, 32'h1);
    instr_i = 32'h20010003;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("held_ready", instr_ready_o, 1'b0);
      check("held_head", imm_o, 32'h1);
    end
    ready_i = 1'b1;
    push(32'h20010003);
    check("order_third", imm_o, 32'h3);
    @(negedge clk_i);

    // table sweep with varying back-pressure
    for (int i = 0; i < 12; i++) begin
      ready_i = $urandom_range(0, 1);
      if (!instr_ready_o) ready_i = 1'b1;
      push(table_w[i]);
    end
    ready_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // illegal counter saturation
    for (int i = 0; i < 300; i++) push(32'hFC000000 | i);
    check("sat_cnt", illegal_cnt_o, 8'd255);
    check("sat_ctrl", ctrl_o, 4'd15);
    check("sat_illegal", illegal_o, 1'b1);
    @(negedge clk_i);

    // reset with a full FIFO
    ready_i = 1'b0;
    push(32'h20010005);
    push(32'h20010006);
    check("prerst_full", instr_ready_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_ready", instr_ready_o, 1'b1);
    check("midrst_cnt", illegal_cnt_o, 8'd0);
    check("midrst_ctrl", ctrl_o, 4'd0);
    ready_i = 1'b1;
    push(32'h00221823);
    check("postrst_ctrl", ctrl_o, 4'd6);
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
